// File: rtl/backtrack_timer.sv
// Bumper-triggered backtrack timer: per-bumper debounce, AND/OR trigger
// combine, and a three-state IDLE/ACTIVE/COOLDOWN sequencer that counts
// whole seconds derived from a sub-second clock-cycle counter.
module backtrack_timer #(
    parameter int CLK_HZ       = 100000000,
    parameter int HOLD_S       = 5,
    parameter int N_BUMP       = 2,
    parameter int MODE         = 0,
    parameter int DEBOUNCE_CYC = 1000,
    parameter int COOLDOWN_S   = 1,
    parameter int RETRIGGER    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_BUMP-1:0] bumper,
    input  logic              enable,
    input  logic              abort,
    output logic              backtrack_active,
    output logic              cooldown_active,
    output logic [3:0]        secs_left,
    output logic              done_pulse
);
    localparam int SUB_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int DB_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CLK_HZ - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'((DEBOUNCE_CYC > 0) ? DEBOUNCE_CYC - 1 : 0);
    localparam logic [3:0]       HOLD_LD  = 4'(HOLD_S);
    localparam logic [3:0]       COOL_LD  = 4'(COOLDOWN_S);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_COOLDOWN
    } state_t;

    logic [N_BUMP-1:0] db;
    logic              trig;
    logic              trig_prev_reg;
    logic              trig_rise;

    state_t            state_reg, state_next;
    logic [SUB_W-1:0]  sub_reg, sub_next;
    logic [3:0]        secs_reg, secs_next;
    logic              done_reg, done_next;
    logic              sec_wrap;
    logic              last_cycle;
    logic              retrig;

    genvar gi;
    generate
        for (gi = 0; gi < N_BUMP; gi++) begin : g_db
            logic db_bit_reg;
            if (DEBOUNCE_CYC == 0) begin : g_bypass
                // Bypass: debounced bit is the raw bit delayed one cycle
                always_ff @(posedge clk) begin
                    if (rst) db_bit_reg <= 1'b0;
                    else     db_bit_reg <= bumper[gi];
                end
            end else begin : g_filt
                logic [DB_W-1:0] cnt_reg;
                // Accept the raw level only after it has differed for DEBOUNCE_CYC straight cycles
                always_ff @(posedge clk) begin
                    if (rst) begin
                        cnt_reg    <= '0;
                        db_bit_reg <= 1'b0;
                    end else if (bumper[gi] == db_bit_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == DB_LAST) begin
                        cnt_reg    <= '0;
                        db_bit_reg <= bumper[gi];
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end
            assign db[gi] = db_bit_reg;
        end
    endgenerate

    assign trig      = (MODE != 0) ? (|db) : (&db);
    assign trig_rise = trig & ~trig_prev_reg;

    // Previous-cycle trigger level for rising-edge detection
    always_ff @(posedge clk) begin
        if (rst) trig_prev_reg <= 1'b0;
        else     trig_prev_reg <= trig;
    end

    assign sec_wrap   = (sub_reg == SUB_LAST);
    assign last_cycle = sec_wrap && (secs_reg == 4'd1);
    assign retrig     = (RETRIGGER != 0) && trig_rise;

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            sub_reg   <= '0;
            secs_reg  <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            sub_reg   <= sub_next;
            secs_reg  <= secs_next;
            done_reg  <= done_next;
        end
    end

    // Next-state logic; ACTIVE and COOLDOWN share the second/sub-second counters
    always_comb begin
        state_next = state_reg;
        sub_next   = sub_reg;
        secs_next  = secs_reg;
        done_next  = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (trig && enable) begin
                    state_next = S_ACTIVE;
                    sub_next   = '0;
                    secs_next  = HOLD_LD;
                end
            end
            S_ACTIVE: begin
                if (abort) begin
                    state_next = S_IDLE;
                    sub_next   = '0;
                    secs_next  = '0;
                end else if (retrig) begin
                    // Retrigger outranks expiry, so a coincident edge extends the hold
                    sub_next  = '0;
                    secs_next = HOLD_LD;
                end else if (last_cycle) begin
                    done_next = 1'b1;
                    sub_next  = '0;
                    if (COOLDOWN_S > 0) begin
                        state_next = S_COOLDOWN;
                        secs_next  = COOL_LD;
                    end else begin
                        state_next = S_IDLE;
                        secs_next  = '0;
                    end
                end else if (sec_wrap) begin
                    sub_next  = '0;
                    secs_next = secs_reg - 4'd1;
                end else begin
                    sub_next = sub_reg + 1'b1;
                end
            end
            S_COOLDOWN: begin
                if (abort || last_cycle) begin
                    state_next = S_IDLE;
                    sub_next   = '0;
                    secs_next  = '0;
                end else if (sec_wrap) begin
                    sub_next  = '0;
                    secs_next = secs_reg - 4'd1;
                end else begin
                    sub_next = sub_reg + 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
                sub_next   = '0;
                secs_next  = '0;
            end
        endcase
    end

    assign backtrack_active = (state_reg == S_ACTIVE);
    assign cooldown_active  = (state_reg == S_COOLDOWN);
    assign secs_left        = (state_reg == S_ACTIVE) ? secs_reg : 4'd0;
    assign done_pulse       = done_reg;

endmodule
